shift_operand_decoder: RTL and testbench

Initiator side of the barrel-shifter interface, turning the ARM data-processing operand2 field into shifter commands. Accepts an operand2 field, I bit and current C flag, and reads Rm/Rs from the register file. It then drives sh_data/sh_num/sh_op/sh_carry_flag into the shifter, waits for the shifter result and returns the shifted operand plus shifter carry. It sits between instruction decode and the ALU operand-B path.

---
 rtl/shift_operand_decoder_if.sv | 46 ++++
 rtl/shift_operand_decoder.sv | 184 ++++++++++++++++++
 tb/tb_shift_operand_decoder.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_operand_decoder_if.sv
// Operand2 decoder bus: request, register-file read, shifter and result.
// slave = decoder side, master = environment side.
interface shift_operand_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_i_bit;
    logic [11:0] in_op2;
    logic        in_carry;
    logic [3:0]  rf_ra_idx;
    logic [3:0]  rf_rb_idx;
    logic [31:0] rf_ra_data;
    logic [31:0] rf_rb_data;
    logic [31:0] sh_data;
    logic [7:0]  sh_num;
    logic [2:0]  sh_op;
    logic        sh_carry_flag;
    logic [31:0] sh_out;
    logic        sh_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_carry;
    logic        out_err;

    modport slave (
        input  in_valid, in_i_bit, in_op2, in_carry,
        input  rf_ra_data, rf_rb_data,
        input  sh_out, sh_carry,
        input  out_ready,
        output in_ready,
        output rf_ra_idx, rf_rb_idx,
        output sh_data, sh_num, sh_op, sh_carry_flag,
        output out_valid, out_data, out_carry, out_err
    );

    modport master (
        output in_valid, in_i_bit, in_op2, in_carry,
        output rf_ra_data, rf_rb_data,
        output sh_out, sh_carry,
        output out_ready,
        input  in_ready,
        input  rf_ra_idx, rf_rb_idx,
        input  sh_data, sh_num, sh_op, sh_carry_flag,
        input  out_valid, out_data, out_carry, out_err
    );
endinterface

// File: rtl/shift_operand_decoder.sv
// ARM operand2 decoder driving an external barrel shifter.
// Optional macro OP2_ILLEGAL_CHK_EN flags I=0, op2[4]=1, op2[7]=1 encodings.
module shift_operand_decoder #(
    parameter int unsigned SHIFT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    shift_operand_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        i_q;
    logic        c_q;
    logic [11:0] op2_q;
    logic [31:0] rm_q;
    logic [7:0]  rs_q;
    logic [3:0]  cnt;

    logic [31:0] sh_data_q;
    logic [7:0]  sh_num_q;
    logic [2:0]  sh_op_q;
    logic        sh_cf_q;

    logic [31:0] out_data_q;
    logic        out_carry_q;
    logic        out_err_q;

    logic [31:0] dec_data;
    logic [7:0]  dec_num;
    logic [2:0]  dec_op;
    logic        illegal;
    logic        cnt_last;
    logic        no_shift;

`ifdef OP2_ILLEGAL_CHK_EN
    assign illegal = ~i_q & op2_q[4] & op2_q[7];
`else
    assign illegal = 1'b0;
`endif

    assign cnt_last = (cnt == 4'd1);

    // Shifter carry is undefined for a zero register-form amount.
    assign no_shift = sh_op_q[0] && (sh_num_q == 8'd0);

    // Operand2 decode from the latched request and register values.
    always_comb begin
        dec_data = rm_q;
        dec_num  = 8'd0;
        dec_op   = 3'b010;
        if (i_q) begin
            dec_data = {24'd0, op2_q[7:0]};
            dec_num  = {3'd0, op2_q[11:8], 1'b0};
            dec_op   = 3'b111;
        end else if (!op2_q[4]) begin
            dec_data = rm_q;
            dec_num  = {3'd0, op2_q[11:7]};
            dec_op   = {op2_q[6:5], 1'b0};
        end else begin
            dec_data = rm_q;
            dec_num  = rs_q;
            dec_op   = {op2_q[6:5], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nx = READ;
                end
            end
            READ: begin
                state_nx = illegal ? DONE : ISSUE;
            end
            ISSUE: begin
                state_nx = WAIT;
            end
            WAIT: begin
                if (cnt_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Request and register-file operand latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q   <= 1'b0;
            c_q   <= 1'b0;
            op2_q <= 12'd0;
            rm_q  <= 32'd0;
            rs_q  <= 8'd0;
        end else if (state == IDLE && bus.in_valid) begin
            i_q   <= bus.in_i_bit;
            c_q   <= bus.in_carry;
            op2_q <= bus.in_op2;
        end else if (state == READ) begin
            rm_q <= bus.rf_ra_data;
            rs_q <= bus.rf_rb_data[7:0];
        end
    end

    // Shifter command registers and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_data_q <= 32'd0;
            sh_num_q  <= 8'd0;
            sh_op_q   <= 3'b010;
            sh_cf_q   <= 1'b0;
            cnt       <= 4'd0;
        end else if (state == ISSUE) begin
            sh_data_q <= dec_data;
            sh_num_q  <= dec_num;
            sh_op_q   <= dec_op;
            sh_cf_q   <= c_q;
            cnt       <= 4'(SHIFT_LAT);
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Result capture, held through DONE until the consumer accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= 32'd0;
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (state == WAIT && cnt_last) begin
            out_data_q  <= bus.sh_out;
            out_carry_q <= no_shift ? c_q : bus.sh_carry;
            out_err_q   <= 1'b0;
        end else if (state == READ && illegal) begin
            out_data_q  <= 32'd0;
            out_carry_q <= c_q;
            out_err_q   <= 1'b1;
        end else if (state == DONE && bus.out_ready) begin
            out_err_q <= 1'b0;
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.rf_ra_idx     = op2_q[3:0];
    assign bus.rf_rb_idx     = op2_q[11:8];
    assign bus.sh_data       = sh_data_q;
    assign bus.sh_num        = sh_num_q;
    assign bus.sh_op         = sh_op_q;
    assign bus.sh_carry_flag = sh_cf_q;
    assign bus.out_valid     = (state == DONE);
    assign bus.out_data      = out_data_q;
    assign bus.out_carry     = out_carry_q;
    assign bus.out_err       = out_err_q;

endmodule

// File: tb/tb_shift_operand_decoder.sv
// Bench for shift_operand_decoder: register file and shifter models,
// scoreboard of expected results checked on the output handshake.
module tb_shift_operand_decoder;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic pv = 1'b0;

    logic [31:0] rf [16];

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic        e;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];

    shift_operand_decoder_if bus();

    shift_operand_decoder #(.SHIFT_LAT(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // ARM shifter semantics, returns {carry, value}.
    function automatic logic [32:0] barrel(input logic [31:0] d,
                                           input logic [7:0] n,
                                           input logic [1:0] ty,
                                           input logic rg,
                                           input logic cf);
        int a;
        logic [63:0] t;
        a = rg ? int'(n) : int'(n[4:0]);
        if (!rg && a == 0) begin
            case (ty)
                2'd0: return {cf, d};
                2'd1: return {d[31], 32'h0};
                2'd2: return {d[31], {32{d[31]}}};
                default: return {d[0], cf, d[31:1]};
            endcase
        end
        if (a == 0) return {cf, d};
        case (ty)
            2'd0: begin
                if (a < 32) return {d[32-a], d << a};
                if (a == 32) return {d[0], 32'h0};
                return 33'h0;
            end
            2'd1: begin
                if (a < 32) return {d[a-1], d >> a};
                if (a == 32) return {d[31], 32'h0};
                return 33'h0;
            end
            2'd2: begin
                if (a < 32) return {d[a-1], 32'($signed(d) >>> a)};
                return {d[31], {32{d[31]}}};
            end
            default: begin
                a = a % 32;
                if (a == 0) return {d[31], d};
                t = {d, d};
                return {d[a-1], t[a +: 32]};
            end
        endcase
    endfunction

    // External shifter; carry is garbage for a zero register-form amount.
    function automatic logic [32:0] shifter(input logic [31:0] d,
                                            input logic [7:0] n,
                                            input logic [2:0] op,
                                            input logic cf);
        if (op[0] && n == 8'd0) return {~cf, d};
        return barrel(d, n, op[2:1], op[0], cf);
    endfunction

    // Architectural operand2 result, returns {err, carry, value}.
    function automatic logic [33:0] ref_op2(input logic i,
                                            input logic [11:0] op2,
                                            input logic cin,
                                            input logic [31:0] rm,
                                            input logic [31:0] rs);
        logic [32:0] r;
`ifdef OP2_ILLEGAL_CHK_EN
        if (!i && op2[4] && op2[7]) return {1'b1, cin, 32'h0};
`endif
        if (i)
            r = barrel({24'h0, op2[7:0]}, {3'b0, op2[11:8], 1'b0},
                       2'b11, 1'b1, cin);
        else if (!op2[4])
            r = barrel(rm, {3'b0, op2[11:7]}, op2[6:5], 1'b0, cin);
        else
            r = barrel(rm, rs[7:0], op2[6:5], 1'b1, cin);
        return {1'b0, r};
    endfunction

    assign bus.rf_ra_data = rf[bus.rf_ra_idx];
    assign bus.rf_rb_data = rf[bus.rf_rb_idx];
    assign {bus.sh_carry, bus.sh_out} =
        shifter(bus.sh_data, bus.sh_num, bus.sh_op, bus.sh_carry_flag);

    // Scoreboard: latency on out_valid rise, data on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !pv) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid got 1 want 0");
                end else if (cyc - q[0].acc !== q[0].lat) begin
                    fails++;
                    $display("FAIL latency got %0d want %0d",
                             cyc - q[0].acc, q[0].lat);
                end
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                tests++;
                if (bus.out_data !== e.d) begin
                    fails++;
                    $display("FAIL out_data got %h want %h",
                             bus.out_data, e.d);
                end
                tests++;
                if (bus.out_carry !== e.c) begin
                    fails++;
                    $display("FAIL out_carry got %b want %b",
                             bus.out_carry, e.c);
                end
                tests++;
                if (bus.out_err !== e.e) begin
                    fails++;
                    $display("FAIL out_err got %b want %b",
                             bus.out_err, e.e);
                end
            end
        end
        pv = bus.out_valid;
    end

    task automatic send(input logic i, input logic [11:0] op2,
                        input logic cin, input logic [31:0] rm,
                        input logic [31:0] rs, input logic [31:0] ed,
                        input logic ec, input logic ee, output int acc);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout got 0 want 1");
        end
        rf[op2[11:8]] = rs;
        rf[op2[3:0]] = rm;
        bus.in_valid = 1'b1;
        bus.in_i_bit = i;
        bus.in_op2 = op2;
        bus.in_carry = cin;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.in_valid = 1'b0;
        e.d = ed;
        e.c = ec;
        e.e = ee;
        e.acc = acc;
        e.lat = ee ? 1 : 2 + L;
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || !bus.in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout got %0d want 0", q.size());
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_i_bit = 1'b0;
        bus.in_op2 = 12'h0;
        bus.in_carry = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) rf[k] = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_hs got %b%b want 10",
                     bus.in_ready, bus.out_valid);
        end
        tests++;
        if ({bus.out_data, bus.out_carry, bus.out_err} !== 34'h0) begin
            fails++;
            $display("FAIL rst_out got %h %b %b want 0 0 0",
                     bus.out_data, bus.out_carry, bus.out_err);
        end
        tests++;
        if (bus.sh_data !== 32'h0 || bus.sh_num !== 8'h0 ||
            bus.sh_op !== 3'b010 || bus.sh_carry_flag !== 1'b0) begin
            fails++;
            $display("FAIL rst_sh got %h %h %b %b want 0 0 010 0",
                     bus.sh_data, bus.sh_num, bus.sh_op,
                     bus.sh_carry_flag);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_immediate();
        int a;
        send(1'b1, 12'h4FF, 1'b0, 32'h0, 32'h0, 32'hFF000000, 1'b1, 1'b0, a);
        wait_idle();
        tests++;
        if (bus.sh_op !== 3'b111 || bus.sh_num !== 8'd8) begin
            fails++;
            $display("FAIL imm_sh got op=%b num=%h want 111 08",
                     bus.sh_op, bus.sh_num);
        end
        send(1'b1, 12'h0AB, 1'b1, 32'h0, 32'h0, 32'h000000AB, 1'b1, 1'b0, a);
        wait_idle();
    endtask

    task automatic test_reg_imm();
        int a;
        send(1'b0, 12'h001, 1'b1, 32'h12345678, 32'h0,
             32'h12345678, 1'b1, 1'b0, a);
        send(1'b0, 12'h021, 1'b0, 32'h80000001, 32'h0,
             32'h0, 1'b1, 1'b0, a);
        wait_idle();
        tests++;
        if (bus.sh_op !== 3'b010 || bus.sh_num !== 8'd0) begin
            fails++;
            $display("FAIL lsr32_sh got op=%b num=%h want 010 00",
                     bus.sh_op, bus.sh_num);
        end
        send(1'b0, 12'h061, 1'b1, 32'h00000003, 32'h0,
             32'h80000001, 1'b1, 1'b0, a);
        wait_idle();
    endtask

    task automatic test_reg_reg();
        int a;
        send(1'b0, 12'h211, 1'b1, 32'hFFFFFFFF, 32'h21,
             32'h0, 1'b0, 1'b0, a);
        wait_idle();
        tests++;
        if (bus.sh_num !== 8'h21 || bus.sh_op !== 3'b001) begin
            fails++;
            $display("FAIL regsh_sh got op=%b num=%h want 001 21",
                     bus.sh_op, bus.sh_num);
        end
        send(1'b0, 12'h011, 1'b1, 32'hCAFEF00D, 32'h100,
             32'hCAFEF00D, 1'b1, 1'b0, a);
        wait_idle();
    endtask

    task automatic test_stall();
        int a;
        int n;
        bus.out_ready = 1'b0;
        send(1'b0, 12'h211, 1'b0, 32'hFFFFFFFF, 32'h21,
             32'h0, 1'b0, 1'b0, a);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0 ||
                bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall got v=%b d=%h r=%b want 1 0 0",
                         bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_illegal();
        int a;
`ifdef OP2_ILLEGAL_CHK_EN
        send(1'b0, 12'h091, 1'b1, 32'h1, 32'h4, 32'h0, 1'b1, 1'b1, a);
`else
        send(1'b0, 12'h091, 1'b1, 32'h1, 32'h4, 32'h10, 1'b0, 1'b0, a);
`endif
        wait_idle();
        tests++;
        if (bus.out_err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear got %b want 0", bus.out_err);
        end
    endtask

    task automatic test_back_to_back();
        int acc [4];
        logic [33:0] r;
        logic [11:0] op;
        for (int k = 0; k < 4; k++) begin
            op = 12'h0E3 + 12'(k * 12'h101);
            op[4] = 1'b0;
            r = ref_op2(1'b0, op, k[0], 32'h9ABC0000 + k, 32'h0);
            send(1'b0, op, k[0], 32'h9ABC0000 + k, 32'h0,
                 r[31:0], r[32], r[33], acc[k]);
        end
        wait_idle();
        for (int k = 1; k < 4; k++) begin
            tests++;
            if (acc[k] - acc[k-1] !== 4 + L) begin
                fails++;
                $display("FAIL throughput got %0d want %0d",
                         acc[k] - acc[k-1], 4 + L);
            end
        end
    endtask

    task automatic test_random();
        int a;
        logic i;
        logic cin;
        logic [11:0] op;
        logic [31:0] rm;
        logic [31:0] rs;
        logic [33:0] r;
        for (int k = 0; k < 24; k++) begin
            i = 1'($urandom);
            cin = 1'($urandom);
            op = 12'($urandom);
            rm = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? $urandom
                                             : 32'($urandom_range(0, 40));
            if (op[3:0] == op[11:8]) rs = rm;
            r = ref_op2(i, op, cin, rm, rs);
            send(i, op, cin, rm, rs, r[31:0], r[32], r[33], a);
        end
        wait_idle();
    endtask

    task automatic test_reset_wait();
        int a;
        int seen;
        send(1'b0, 12'h211, 1'b1, 32'hFFFFFFFF, 32'h21,
             32'h0, 1'b0, 1'b0, a);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.sh_num !== 8'h0 || bus.sh_op !== 3'b010 ||
            bus.sh_data !== 32'h0 || bus.sh_carry_flag !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait got r=%b v=%b num=%h op=%b want 1 0 00 010",
                     bus.in_ready, bus.out_valid, bus.sh_num, bus.sh_op);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_no_valid got %0d want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_reg_imm();
        test_reg_reg();
        test_stall();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
